// File: rtl/tlrot_arb_pkg.sv
// rtl/tlrot_arb_pkg.sv - shared types and TL-UL field widths for the TLROT host arbiter
package tlrot_arb_pkg;

    localparam int OpW      = 3;
    localparam int SizeW    = 2;
    localparam int SrcW     = 8;
    localparam int AddrW    = 32;
    localparam int DataW    = 32;
    localparam int MaskW    = 4;
    // Sized for the largest supported host count (8) so the entry layout is fixed.
    localparam int HostIdxW = 3;

    typedef struct packed {
        logic                busy;
        logic [HostIdxW-1:0] host_idx;
        logic [SrcW-1:0]     orig_source;
    } slot_entry_t;

endpackage

// File: rtl/tlrot_slot_table.sv
// rtl/tlrot_slot_table.sv - outstanding-transaction table: lowest-free allocation, free by index, lookup, busy count
module tlrot_slot_table
    import tlrot_arb_pkg::*;
#(
    parameter int MaxOut = 4,
    parameter int SlotW  = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_i,
    input  logic [HostIdxW-1:0] alloc_host_i,
    input  logic [SrcW-1:0]     alloc_src_i,
    input  logic                free_i,
    input  logic [SlotW-1:0]    free_idx_i,
    input  logic [SlotW-1:0]    lookup_idx_i,
    output slot_entry_t         lookup_o,
    output logic [SlotW-1:0]    free_slot_o,
    output logic                have_slot_o,
    output logic [SlotW:0]      busy_cnt_o
);

    slot_entry_t        slot_q [MaxOut];
    slot_entry_t        slot_d [MaxOut];
    logic [SlotW:0]     busy_cnt_q;
    logic [SlotW:0]     busy_cnt_d;

    // Descending scan leaves the lowest free index as the final winner.
    always_comb begin
        free_slot_o = '0;
        have_slot_o = 1'b0;
        for (int i = MaxOut - 1; i >= 0; i--) begin
            if (!slot_q[i].busy) begin
                free_slot_o = SlotW'(i);
                have_slot_o = 1'b1;
            end
        end
    end

    always_comb begin
        lookup_o = '0;
        for (int i = 0; i < MaxOut; i++) begin
            if (SlotW'(i) == lookup_idx_i) begin
                lookup_o = slot_q[i];
            end
        end
    end

    // Allocation targets a slot that was free before this cycle, so it never
    // collides with the slot being released in the same cycle.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < MaxOut; i++) begin
            slot_d[i] = slot_q[i];
            if (free_i && (SlotW'(i) == free_idx_i)) begin
                slot_d[i].busy = 1'b0;
            end
            if (alloc_i && (SlotW'(i) == free_slot_o)) begin
                slot_d[i].busy        = 1'b1;
                slot_d[i].host_idx    = alloc_host_i;
                slot_d[i].orig_source = alloc_src_i;
            end
            busy_cnt_d = busy_cnt_d + (SlotW + 1)'(slot_d[i].busy);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxOut; i++) begin
                slot_q[i] <= '0;
            end
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < MaxOut; i++) begin
                slot_q[i] <= slot_d[i];
            end
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: rtl/tlrot_host_arb.sv
// rtl/tlrot_host_arb.sv - round-robin TL-UL host arbiter with source rewrite in front of the TLROT slave port
module tlrot_host_arb
    import tlrot_arb_pkg::*;
#(
    parameter int NumHosts = 2,
    parameter int MaxOut   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumHosts-1:0]       h_a_valid_i,
    output logic [NumHosts-1:0]       h_a_ready_o,
    input  logic [NumHosts*OpW-1:0]   h_a_opcode_i,
    input  logic [NumHosts*OpW-1:0]   h_a_param_i,
    input  logic [NumHosts*SizeW-1:0] h_a_size_i,
    input  logic [NumHosts*SrcW-1:0]  h_a_source_i,
    input  logic [NumHosts*AddrW-1:0] h_a_address_i,
    input  logic [NumHosts*MaskW-1:0] h_a_mask_i,
    input  logic [NumHosts*DataW-1:0] h_a_data_i,
    output logic [NumHosts-1:0]       h_d_valid_o,
    input  logic [NumHosts-1:0]       h_d_ready_i,
    output logic [OpW-1:0]            h_d_opcode_o,
    output logic [OpW-1:0]            h_d_param_o,
    output logic [SizeW-1:0]          h_d_size_o,
    output logic [SrcW-1:0]           h_d_source_o,
    output logic                      h_d_sink_o,
    output logic [DataW-1:0]          h_d_data_o,
    output logic                      h_d_denied_o,
    output logic                      a_valid_o,
    input  logic                      a_ready_i,
    output logic [OpW-1:0]            a_opcode_o,
    output logic [OpW-1:0]            a_param_o,
    output logic [SizeW-1:0]          a_size_o,
    output logic [SrcW-1:0]           a_source_o,
    output logic [AddrW-1:0]          a_address_o,
    output logic [MaskW-1:0]          a_mask_o,
    output logic [DataW-1:0]          a_data_o,
    input  logic                      d_valid_i,
    output logic                      d_ready_o,
    input  logic [OpW-1:0]            d_opcode_i,
    input  logic [OpW-1:0]            d_param_i,
    input  logic [SizeW-1:0]          d_size_i,
    input  logic [SrcW-1:0]           d_source_i,
    input  logic                      d_sink_i,
    input  logic [DataW-1:0]          d_data_i,
    input  logic                      d_denied_i,
    output logic [$clog2(MaxOut > 1 ? MaxOut : 2):0] busy_cnt_o,
    output logic                      route_err_o
);

    localparam int SlotW = (MaxOut > 1) ? $clog2(MaxOut) : 1;
    localparam int HostW = $clog2(NumHosts);

    logic [HostW-1:0]    rr_ptr_q, rr_ptr_d;
    logic                lock_vld_q, lock_vld_d;
    logic [HostW-1:0]    lock_host_q, lock_host_d;
    logic                route_err_q, route_err_d;

    logic [HostW-1:0]    grant;
    logic [HostW-1:0]    cand;
    logic                found;
    logic [SlotW-1:0]    free_slot;
    logic                have_slot;
    logic                a_fire;
    logic [SlotW-1:0]    d_idx;
    slot_entry_t         d_entry;
    logic                d_hit;
    logic                d_sel_ready;
    logic                d_fire;

    tlrot_slot_table #(
        .MaxOut (MaxOut),
        .SlotW  (SlotW)
    ) u_slot_table (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alloc_i      (a_fire),
        .alloc_host_i (HostIdxW'(grant)),
        .alloc_src_i  (h_a_source_i[grant*SrcW +: SrcW]),
        .free_i       (d_fire),
        .free_idx_i   (d_idx),
        .lookup_idx_i (d_idx),
        .lookup_o     (d_entry),
        .free_slot_o  (free_slot),
        .have_slot_o  (have_slot),
        .busy_cnt_o   (busy_cnt_o)
    );

    always_comb begin
        grant = rr_ptr_q;
        cand  = '0;
        found = 1'b0;
        if (lock_vld_q) begin
            grant = lock_host_q;
        end else begin
            for (int k = 0; k < NumHosts; k++) begin
                cand = HostW'((int'(rr_ptr_q) + k) % NumHosts);
                if (!found && h_a_valid_i[cand]) begin
                    grant = cand;
                    found = 1'b1;
                end
            end
        end
    end

    // Handshake outputs are held low while reset is asserted.
    always_comb begin
        a_valid_o   = rst_ni & have_slot & h_a_valid_i[grant];
        a_fire      = a_valid_o & a_ready_i;
        h_a_ready_o = '0;
        h_a_ready_o[grant] = rst_ni & have_slot & a_ready_i;
        a_opcode_o  = h_a_opcode_i[grant*OpW +: OpW];
        a_param_o   = h_a_param_i[grant*OpW +: OpW];
        a_size_o    = h_a_size_i[grant*SizeW +: SizeW];
        a_address_o = h_a_address_i[grant*AddrW +: AddrW];
        a_mask_o    = h_a_mask_i[grant*MaskW +: MaskW];
        a_data_o    = h_a_data_i[grant*DataW +: DataW];
        a_source_o  = SrcW'(free_slot);
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_vld_d  = lock_vld_q;
        lock_host_d = lock_host_q;
        if (a_fire) begin
            rr_ptr_d   = HostW'((int'(grant) + 1) % NumHosts);
            lock_vld_d = 1'b0;
        end else if (a_valid_o) begin
            lock_vld_d  = 1'b1;
            lock_host_d = grant;
        end
    end

    assign d_idx = d_source_i[SlotW-1:0];
    assign d_hit = (d_source_i < SrcW'(MaxOut)) && d_entry.busy;

    always_comb begin
        h_d_valid_o = '0;
        d_sel_ready = 1'b0;
        for (int h = 0; h < NumHosts; h++) begin
            if (d_hit && (d_entry.host_idx == HostIdxW'(h))) begin
                h_d_valid_o[h] = rst_ni & d_valid_i;
                d_sel_ready    = h_d_ready_i[h];
            end
        end
        // Beats for unknown slots are swallowed so the slave never stalls on them.
        d_ready_o    = rst_ni & (d_hit ? d_sel_ready : d_valid_i);
        d_fire       = d_hit & d_valid_i & d_ready_o;
        route_err_d  = route_err_q | (rst_ni & d_valid_i & ~d_hit);
        h_d_source_o = d_hit ? d_entry.orig_source : d_source_i;
        h_d_opcode_o = d_opcode_i;
        h_d_param_o  = d_param_i;
        h_d_size_o   = d_size_i;
        h_d_sink_o   = d_sink_i;
        h_d_data_o   = d_data_i;
        h_d_denied_o = d_denied_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            lock_vld_q  <= 1'b0;
            lock_host_q <= '0;
            route_err_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_vld_q  <= lock_vld_d;
            lock_host_q <= lock_host_d;
            route_err_q <= route_err_d;
        end
    end

    assign route_err_o = route_err_q;

endmodule

// File: tb/tb_tlrot_host_arb.sv
// tb/tb_tlrot_host_arb.sv - directed self-checking bench for tlrot_host_arb
module tb_tlrot_host_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  h_a_valid_i;
    logic [1:0]  h_a_ready_o;
    logic [5:0]  h_a_opcode_i;
    logic [5:0]  h_a_param_i;
    logic [3:0]  h_a_size_i;
    logic [15:0] h_a_source_i;
    logic [63:0] h_a_address_i;
    logic [7:0]  h_a_mask_i;
    logic [63:0] h_a_data_i;
    logic [1:0]  h_d_valid_o;
    logic [1:0]  h_d_ready_i;
    logic [2:0]  h_d_opcode_o, h_d_param_o;
    logic [1:0]  h_d_size_o;
    logic [7:0]  h_d_source_o;
    logic        h_d_sink_o;
    logic [31:0] h_d_data_o;
    logic        h_d_denied_o;
    logic        a_valid_o, a_ready_i;
    logic [2:0]  a_opcode_o, a_param_o;
    logic [1:0]  a_size_o;
    logic [7:0]  a_source_o;
    logic [31:0] a_address_o;
    logic [3:0]  a_mask_o;
    logic [31:0] a_data_o;
    logic        d_valid_i, d_ready_o;
    logic [2:0]  d_opcode_i, d_param_i;
    logic [1:0]  d_size_i;
    logic [7:0]  d_source_i;
    logic        d_sink_i;
    logic [31:0] d_data_i;
    logic        d_denied_i;
    logic [2:0]  busy_cnt_o;
    logic        route_err_o;

    int checks = 0;
    int failures = 0;

    tlrot_host_arb #(.NumHosts(2), .MaxOut(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .h_a_valid_i(h_a_valid_i), .h_a_ready_o(h_a_ready_o),
        .h_a_opcode_i(h_a_opcode_i), .h_a_param_i(h_a_param_i),
        .h_a_size_i(h_a_size_i), .h_a_source_i(h_a_source_i),
        .h_a_address_i(h_a_address_i), .h_a_mask_i(h_a_mask_i),
        .h_a_data_i(h_a_data_i),
        .h_d_valid_o(h_d_valid_o), .h_d_ready_i(h_d_ready_i),
        .h_d_opcode_o(h_d_opcode_o), .h_d_param_o(h_d_param_o),
        .h_d_size_o(h_d_size_o), .h_d_source_o(h_d_source_o),
        .h_d_sink_o(h_d_sink_o), .h_d_data_o(h_d_data_o),
        .h_d_denied_o(h_d_denied_o),
        .a_valid_o(a_valid_o), .a_ready_i(a_ready_i),
        .a_opcode_o(a_opcode_o), .a_param_o(a_param_o), .a_size_o(a_size_o),
        .a_source_o(a_source_o), .a_address_o(a_address_o),
        .a_mask_o(a_mask_o), .a_data_o(a_data_o),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o),
        .d_opcode_i(d_opcode_i), .d_param_i(d_param_i), .d_size_i(d_size_i),
        .d_source_i(d_source_i), .d_sink_i(d_sink_i), .d_data_i(d_data_i),
        .d_denied_i(d_denied_i),
        .busy_cnt_o(busy_cnt_o), .route_err_o(route_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        h_a_valid_i = '0; h_a_opcode_i = '0; h_a_param_i = '0; h_a_size_i = '0;
        h_a_source_i = '0; h_a_address_i = '0; h_a_mask_i = '0; h_a_data_i = '0;
        h_d_ready_i = 2'b11; a_ready_i = 1'b0;
        d_valid_i = 1'b0; d_opcode_i = 3'd1; d_param_i = '0; d_size_i = 2'd2;
        d_source_i = '0; d_sink_i = 1'b0; d_data_i = '0; d_denied_i = 1'b0;
    endtask

    task automatic set_host(input int h, input logic v, input logic [7:0] src, input logic [31:0] addr);
        h_a_valid_i[h]           = v;
        h_a_opcode_i[h*3 +: 3]   = 3'd4;
        h_a_size_i[h*2 +: 2]     = 2'd2;
        h_a_mask_i[h*4 +: 4]     = 4'hF;
        h_a_source_i[h*8 +: 8]   = src;
        h_a_address_i[h*32 +: 32] = addr;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        #3;
        checks++;
        if (busy_cnt_o !== 3'd0 || route_err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state busy=%0d err=%0b exp busy=0 err=0", busy_cnt_o, route_err_o);
        end
        checks++;
        if (a_valid_o !== 1'b0 || h_a_ready_o !== 2'b00 || h_d_valid_o !== 2'b00 || d_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake av=%0b har=%b hdv=%b dr=%0b exp all 0", a_valid_o, h_a_ready_o, h_d_valid_o, d_ready_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        set_host(0, 1'b1, 8'h2A, 32'h1000);
        a_ready_i = 1'b1;
        #1;
        checks++;
        if (a_valid_o !== 1'b1 || a_source_o !== 8'h00 || a_address_o !== 32'h1000 || h_a_ready_o !== 2'b01) begin
            failures++;
            $display("FAIL single_a av=%0b src=%h addr=%h har=%b exp 1/00/1000/01", a_valid_o, a_source_o, a_address_o, h_a_ready_o);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (busy_cnt_o !== 3'd1) begin
            failures++;
            $display("FAIL single_busy1 got=%0d exp=1", busy_cnt_o);
        end
        d_valid_i = 1'b1; d_source_i = 8'd0; d_data_i = 32'hDEADBEEF;
        #1;
        checks++;
        if (h_d_valid_o !== 2'b01 || h_d_source_o !== 8'h2A || d_ready_o !== 1'b1 || h_d_data_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_d hdv=%b src=%h dr=%0b data=%h exp 01/2a/1/deadbeef", h_d_valid_o, h_d_source_o, d_ready_o, h_d_data_o);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (busy_cnt_o !== 3'd0) begin
            failures++;
            $display("FAIL single_busy0 got=%0d exp=0", busy_cnt_o);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt [4];
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
        do_reset();
        set_host(0, 1'b1, 8'h11, 32'h2000);
        set_host(1, 1'b1, 8'h11, 32'h3000);
        a_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (h_a_ready_o !== exp_gnt[i] || a_source_o !== 8'(i) || a_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL contention_%0d har=%b src=%h av=%0b exp har=%b src=%0d av=1", i, h_a_ready_o, a_source_o, a_valid_o, exp_gnt[i], i);
            end
            tick();
        end
    endtask

    task automatic test_table_full();
        #1;
        checks++;
        if (busy_cnt_o !== 3'd4 || a_valid_o !== 1'b0 || h_a_ready_o !== 2'b00) begin
            failures++;
            $display("FAIL full_block busy=%0d av=%0b har=%b exp 4/0/00", busy_cnt_o, a_valid_o, h_a_ready_o);
        end
        d_valid_i = 1'b1; d_source_i = 8'd2;
        #1;
        checks++;
        if (h_d_valid_o !== 2'b01 || h_d_source_o !== 8'h11 || a_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL full_free2 hdv=%b src=%h av=%0b exp 01/11/0", h_d_valid_o, h_d_source_o, a_valid_o);
        end
        tick();
        d_valid_i = 1'b0;
        #1;
        checks++;
        if (a_valid_o !== 1'b1 || a_source_o !== 8'd2 || h_a_ready_o !== 2'b01 || busy_cnt_o !== 3'd3) begin
            failures++;
            $display("FAIL full_realloc av=%0b src=%h har=%b busy=%0d exp 1/02/01/3", a_valid_o, a_source_o, h_a_ready_o, busy_cnt_o);
        end
    endtask

    task automatic test_simultaneous();
        d_valid_i = 1'b1; d_source_i = 8'd0;
        #1;
        checks++;
        if (h_d_valid_o !== 2'b01 || a_valid_o !== 1'b1 || a_source_o !== 8'd2) begin
            failures++;
            $display("FAIL simul_comb hdv=%b av=%0b src=%h exp 01/1/02", h_d_valid_o, a_valid_o, a_source_o);
        end
        tick();
        d_valid_i = 1'b0;
        #1;
        checks++;
        if (busy_cnt_o !== 3'd3 || a_source_o !== 8'd0 || h_a_ready_o !== 2'b10) begin
            failures++;
            $display("FAIL simul_after busy=%0d src=%h har=%b exp 3/00/10", busy_cnt_o, a_source_o, h_a_ready_o);
        end
        clear_inputs();
    endtask

    task automatic test_stall_lock();
        do_reset();
        set_host(0, 1'b1, 8'h01, 32'hA0);
        set_host(1, 1'b1, 8'h02, 32'hB0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (a_valid_o !== 1'b1 || a_address_o !== 32'hA0 || h_a_ready_o !== 2'b00) begin
                failures++;
                $display("FAIL stall_%0d av=%0b addr=%h har=%b exp 1/a0/00", i, a_valid_o, a_address_o, h_a_ready_o);
            end
            tick();
        end
        a_ready_i = 1'b1;
        #1;
        checks++;
        if (h_a_ready_o !== 2'b01 || a_source_o !== 8'd0) begin
            failures++;
            $display("FAIL stall_fire har=%b src=%h exp 01/00", h_a_ready_o, a_source_o);
        end
        tick();
        checks++;
        if (a_address_o !== 32'hB0 || h_a_ready_o !== 2'b10 || a_source_o !== 8'd1) begin
            failures++;
            $display("FAIL stall_next addr=%h har=%b src=%h exp b0/10/01", a_address_o, h_a_ready_o, a_source_o);
        end
        tick();
        a_ready_i = 1'b0;
        set_host(0, 1'b0, 8'h01, 32'hA0);
        set_host(1, 1'b1, 8'h02, 32'hB4);
        tick();
        set_host(0, 1'b1, 8'h01, 32'hA0);
        #1;
        checks++;
        if (a_address_o !== 32'hB4 || a_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_lock_hold addr=%h av=%0b exp b4/1", a_address_o, a_valid_o);
        end
        a_ready_i = 1'b1;
        #1;
        checks++;
        if (h_a_ready_o !== 2'b10) begin
            failures++;
            $display("FAIL stall_lock_fire har=%b exp 10", h_a_ready_o);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_out_of_order();
        do_reset();
        a_ready_i = 1'b1;
        set_host(1, 1'b1, 8'h05, 32'h40);
        tick();
        set_host(1, 1'b0, 8'h05, 32'h40);
        set_host(0, 1'b1, 8'h09, 32'h44);
        tick();
        clear_inputs();
        h_d_ready_i = 2'b10;
        d_valid_i = 1'b1; d_source_i = 8'd1;
        #1;
        checks++;
        if (h_d_valid_o !== 2'b01 || h_d_source_o !== 8'h09 || d_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL ooo_slot1_wait hdv=%b src=%h dr=%0b exp 01/09/0", h_d_valid_o, h_d_source_o, d_ready_o);
        end
        tick();
        h_d_ready_i = 2'b01;
        #1;
        checks++;
        if (busy_cnt_o !== 3'd2 || d_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ooo_slot1_go busy=%0d dr=%0b exp 2/1", busy_cnt_o, d_ready_o);
        end
        tick();
        d_source_i = 8'd0;
        #1;
        checks++;
        if (h_d_valid_o !== 2'b10 || h_d_source_o !== 8'h05 || d_ready_o !== 1'b0 || busy_cnt_o !== 3'd1) begin
            failures++;
            $display("FAIL ooo_slot0_wait hdv=%b src=%h dr=%0b busy=%0d exp 10/05/0/1", h_d_valid_o, h_d_source_o, d_ready_o, busy_cnt_o);
        end
        h_d_ready_i = 2'b10;
        #1;
        checks++;
        if (d_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ooo_slot0_go dr=%0b exp 1", d_ready_o);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (busy_cnt_o !== 3'd0) begin
            failures++;
            $display("FAIL ooo_drain busy=%0d exp 0", busy_cnt_o);
        end
    endtask

    task automatic test_bad_d();
        d_valid_i = 1'b1; d_source_i = 8'd7;
        #1;
        checks++;
        if (h_d_valid_o !== 2'b00 || d_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bad_d_comb hdv=%b dr=%0b exp 00/1", h_d_valid_o, d_ready_o);
        end
        tick();
        d_valid_i = 1'b0;
        tick();
        tick();
        checks++;
        if (route_err_o !== 1'b1) begin
            failures++;
            $display("FAIL bad_d_sticky err=%0b exp 1", route_err_o);
        end
    endtask

    task automatic test_reset_mid();
        a_ready_i = 1'b1;
        set_host(0, 1'b1, 8'h33, 32'h50);
        set_host(1, 1'b1, 8'h44, 32'h54);
        tick();
        tick();
        d_valid_i = 1'b1; d_source_i = 8'd0;
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (busy_cnt_o !== 3'd0 || route_err_o !== 1'b0 || a_valid_o !== 1'b0 || h_a_ready_o !== 2'b00
            || h_d_valid_o !== 2'b00 || d_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid busy=%0d err=%0b av=%0b har=%b hdv=%b dr=%0b exp all 0",
                     busy_cnt_o, route_err_o, a_valid_o, h_a_ready_o, h_d_valid_o, d_ready_o);
        end
        clear_inputs();
        tick();
        rst_ni = 1'b1;
        tick();
        d_valid_i = 1'b1; d_source_i = 8'd0;
        #1;
        checks++;
        if (h_d_valid_o !== 2'b00 || d_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_cleared hdv=%b dr=%0b exp 00/1", h_d_valid_o, d_ready_o);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_ni = 1'b1;
        #2;
        test_reset();
        test_single();
        test_contention();
        test_table_full();
        test_simultaneous();
        test_stall_lock();
        test_out_of_order();
        test_bad_d();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlrot_host_arb.md
Name:
tlrot_host_arb

Overview:
- Shares the single TL-UL slave port of the TLROT root-of-trust wrapper between NumHosts upstream TL-UL requesters (e.g. core MMIO path, debug module, DMA).
- Round-robin arbitration on channel A with grant lock while stalled.
- Downstream source is rewritten to a slot index from an outstanding-transaction table; channel D is routed back to the owning host with its original source restored.
- Sits between the SoC TileLink fabric and the TLROT wrapper's flat A/D ports.

Parameters:
- NumHosts, 2, number of upstream requesters (2..8).
- MaxOut, 4, outstanding-table depth, i.e. total in-flight requests (1..16).
- SlotW, $clog2(MaxOut) min 1, width of the slot index; derived, not overridable.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset, asynchronous, active-low.
- h_a_valid_i, in, NumHosts, per-host A valid.
- h_a_ready_o, out, NumHosts, per-host A ready.
- h_a_opcode_i, in, NumHosts*3, per-host A opcode.
- h_a_param_i, in, NumHosts*3, per-host A param.
- h_a_size_i, in, NumHosts*2, per-host A size.
- h_a_source_i, in, NumHosts*8, per-host A source.
- h_a_address_i, in, NumHosts*32, per-host A address.
- h_a_mask_i, in, NumHosts*4, per-host A mask.
- h_a_data_i, in, NumHosts*32, per-host A data.
- h_d_valid_o, out, NumHosts, per-host D valid.
- h_d_ready_i, in, NumHosts, per-host D ready.
- h_d_opcode_o / h_d_param_o / h_d_size_o / h_d_source_o / h_d_sink_o / h_d_data_o / h_d_denied_o, out, 3/3/2/8/1/32/1, D fields broadcast to all hosts; qualified only by h_d_valid_o.
- a_valid_o, a_ready_i, a_opcode_o, a_param_o, a_size_o, a_source_o(8), a_address_o, a_mask_o, a_data_o: downstream A channel, widths as above.
- d_valid_i, d_ready_o, d_opcode_i, d_param_i, d_size_i, d_source_i(8), d_sink_i, d_data_i, d_denied_i: downstream D channel.
- busy_cnt_o, out, SlotW+1, number of occupied slots.
- route_err_o, out, 1, sticky: a D beat arrived for a free or out-of-range slot.

Behaviour:
- Reset:
  - all slots free; rr_ptr=0; lock_vld=0; route_err_o=0; busy_cnt_o=0.
  - All valid/ready outputs are 0. Reset mid-transaction discards every table entry; no D beat is replayed.
- Slot table:
  - MaxOut entries {busy, host_idx, orig_source[7:0]}.
  - free_slot is the lowest-index entry with busy=0, taken from registered state.
  - have_slot = any entry free.
- A arbitration, combinational from registered state:
  - If lock_vld, grant = lock_host.
  - Otherwise grant = first host with h_a_valid_i set, scanning upward from rr_ptr with wrap.
- A outputs:
  - a_valid_o = have_slot & h_a_valid_i[grant]. A fields muxed from the granted host.
  - a_source_o = zero-extended free_slot.
  - h_a_ready_o[grant] = have_slot & a_ready_i; all other bits 0.
- A fire (a_valid_o & a_ready_i):
  - slot[free_slot] <= {1, grant, h_a_source_i[grant]}.
  - rr_ptr <= (grant+1) mod NumHosts; lock_vld <= 0.
- Stall (a_valid_o & !a_ready_i): lock_vld <= 1, lock_host <= grant. Fields and grant stay stable until fire, per TL valid-stability.
- No free slot: a_valid_o=0 and all h_a_ready_o=0. The lock is held if it was already set. rr_ptr is unchanged.
- D routing, fully combinational, zero latency:
  - idx = d_source_i[SlotW-1:0].
  - Hit = d_source_i < MaxOut & slot[idx].busy.
  - On hit: h_d_valid_o[slot.host_idx] = d_valid_i; d_ready_o = h_d_ready_i[host_idx]; h_d_source_o = slot.orig_source; the remaining fields pass through.
  - On miss with d_valid_i: all h_d_valid_o=0, d_ready_o=1 (beat dropped), route_err_o <= 1 (sticky until reset).
- D fire on hit: slot[idx].busy <= 0.
- Simultaneous A fire and D fire in the same cycle:
  - Both updates apply.
  - Allocation uses the pre-cycle free vector, so a slot freed this cycle is only reusable next cycle.
  - busy_cnt_o nets +1-1 = 0.
- Upstream source values may collide across hosts; the rewrite makes downstream IDs unique.
- busy_cnt_o is registered and equals the popcount of the busy bits.

Decomposition:
- Package tlrot_arb_pkg:
  - slot_entry_t struct {busy, host_idx, orig_source}.
  - Constants for the TL-UL field widths (OpW=3, SizeW=2, SrcW=8, AddrW=32, DataW=32, MaskW=4).
- Sub-module tlrot_slot_table: owns the entry registers, the lowest-free priority encoder, the alloc/free write ports, lookup by idx, and busy_cnt.
- The top level holds the round-robin arbiter, the lock, and the muxes.

Test Plan:
- Single host: host0 Get addr 0x1000 source 0x2A, a_ready_i=1 -> a_source_o=0 and busy_cnt_o=1. Then D with d_source_i=0 -> h_d_valid_o=01, h_d_source_o=0x2A, busy_cnt_o=0.
- Contention: hosts 0 and 1 valid every cycle with a_ready_i=1 -> grants alternate 0,1,0,1 from reset; downstream sources 0,1,2,3.
- Stall lock: host0 valid, a_ready_i=0 for 3 cycles while host1 also valid -> grant stays 0 and fields stay stable; on fire rr_ptr=1, so host1 is granted next.
- Table full: MaxOut=4, four requests with no D -> fifth request sees h_a_ready_o=0 and a_valid_o=0. D for slot 2 -> the next allocation uses slot 2.
- Out-of-order D: outstanding slots 0 (host1, src 5) and 1 (host0, src 9); D for slot 1 then slot 0 -> routed to host0 with src 9, then host1 with src 5. d_ready_o follows the respective h_d_ready_i.
- Bad D: d_valid_i with d_source_i=7 (MaxOut=4) -> no h_d_valid_o, d_ready_o=1, route_err_o=1 and held. Async rst_ni low mid-burst -> outputs 0 immediately and the table clears.
